// File: rtl/mem_arb_nch.sv
// mem_arb_nch: N-channel arbiter in front of a single-outstanding memory
// controller port.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_wr         per-channel request valid and direction (1 = write)
//   req_addr/req_wdata       per-channel address and write line, channel k in slice k
//   req_ready                one-hot accept strobe, combinational in IDLE
//   resp_valid/resp_err      one-hot completion pulse and timeout flag
//   resp_rdata               last captured read line, shared by all channels
//   op/io_addr               memory command (00 idle, 01 read, 10 write) and address
//   common_data_bus_out/_in  write line to and read line from the controller
//   tx_done/rd_valid         write completion and read data strobes
//   busy_cycles              free-running count of non-IDLE cycles
module mem_arb_nch #(
  parameter int NUM_CH      = 4,
  parameter int LINE_SIZE   = 512,
  parameter int ADDR_W      = 32,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           req_valid,
  input  logic [NUM_CH-1:0]           req_wr,
  input  logic [NUM_CH*ADDR_W-1:0]    req_addr,
  input  logic [NUM_CH*LINE_SIZE-1:0] req_wdata,
  output logic [NUM_CH-1:0]           req_ready,
  output logic [NUM_CH-1:0]           resp_valid,
  output logic                        resp_err,
  output logic [LINE_SIZE-1:0]        resp_rdata,
  output logic [1:0]                  op,
  output logic [ADDR_W-1:0]           io_addr,
  output logic [LINE_SIZE-1:0]        common_data_bus_out,
  input  logic [LINE_SIZE-1:0]        common_data_bus_in,
  input  logic                        tx_done,
  input  logic                        rd_valid,
  output logic [63:0]                 busy_cycles
);

  localparam int IW = $clog2(NUM_CH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   wr_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          ptr_q;
  logic [IW-1:0]          ptr_d;
  logic [TW-1:0]          tmo_q;
  logic [1:0]             op_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [LINE_SIZE-1:0]   wdata_q;
  logic [LINE_SIZE-1:0]   rdata_q;
  logic [NUM_CH-1:0]      resp_valid_q;
  logic                   resp_err_q;
  logic [63:0]            busy_cycles_q;

  logic                   gnt_any;
  logic [IW-1:0]          gnt_idx;
  logic [IW:0]            cand;
  logic                   sel_wr;
  logic [ADDR_W-1:0]      sel_addr;
  logic [LINE_SIZE-1:0]   sel_wdata;
  logic                   rd_done;
  logic                   wr_done;
  logic                   tmo_hit;

  // Winner search. In round-robin mode the scan starts at the pointer and
  // wraps; the extra bit in cand keeps ptr+i from overflowing before the wrap.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (RR_MODE != 0) begin
        cand = {1'b0, ptr_q} + (IW+1)'(i);
        if (cand >= (IW+1)'(NUM_CH)) cand = cand - (IW+1)'(NUM_CH);
      end else begin
        cand = (IW+1)'(i);
      end
      if (!gnt_any && req_valid[cand[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  // Payload of the winning channel.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*LINE_SIZE +: LINE_SIZE];
      end
    end
  end

  assign ptr_d = (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + IW'(1);

  // Only the strobe matching the latched direction counts as completion.
  assign rd_done = !wr_q && rd_valid;
  assign wr_done = wr_q && tx_done;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

  // Accept is combinational so a requester sees it in the cycle it is chosen.
  assign req_ready = (state_q == IDLE && gnt_any && !rst) ? (NUM_CH'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_q          <= 1'b0;
      idx_q         <= '0;
      ptr_q         <= '0;
      tmo_q         <= '0;
      op_q          <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      resp_valid_q  <= '0;
      resp_err_q    <= 1'b0;
      busy_cycles_q <= '0;
    end else begin
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      if (state_q != IDLE) busy_cycles_q <= busy_cycles_q + 64'd1;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            wr_q    <= sel_wr;
            idx_q   <= gnt_idx;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            op_q    <= sel_wr ? 2'b10 : 2'b01;
            tmo_q   <= '0;
            if (RR_MODE != 0) ptr_q <= ptr_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // A completion on the last allowed cycle wins over the timeout.
          if (rd_done || wr_done || tmo_hit) begin
            if (rd_done) rdata_q <= common_data_bus_in;
            resp_valid_q <= NUM_CH'(1) << idx_q;
            resp_err_q   <= !(rd_done || wr_done);
            op_q         <= 2'b00;
            state_q      <= RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid          = resp_valid_q;
  assign resp_err            = resp_err_q;
  assign resp_rdata          = rdata_q;
  assign op                  = op_q;
  assign io_addr             = addr_q;
  assign common_data_bus_out = wdata_q;
  assign busy_cycles         = busy_cycles_q;

endmodule

// File: tb/tb_mem_arb_nch.sv
// Bench for mem_arb_nch: one round-robin and one fixed-priority instance,
// only the selected one receives requests. A transaction-level model
// (pending requests, grant pointer, expected response) predicts every check.
module tb_mem_arb_nch;

  localparam int N  = 4;
  localparam int LS = 64;
  localparam int AW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            sel;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*LS-1:0] req_wdata;
  logic [LS-1:0]   bus_in;
  logic            tx_done;
  logic            rd_valid;

  logic [N-1:0]    vin  [2];
  logic [N-1:0]    rdy  [2];
  logic [N-1:0]    rsp  [2];
  logic            err  [2];
  logic [LS-1:0]   rdat [2];
  logic [1:0]      opo  [2];
  logic [AW-1:0]   ioa  [2];
  logic [LS-1:0]   bout [2];
  logic [63:0]     bcy  [2];

  assign vin[0] = sel ? '0 : req_valid;
  assign vin[1] = sel ? req_valid : '0;

  mem_arb_nch #(.NUM_CH(N), .LINE_SIZE(LS), .ADDR_W(AW), .RR_MODE(1), .TIMEOUT_CYC(TO)) u_rr (
    .clk(clk), .rst(rst), .req_valid(vin[0]), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy[0]), .resp_valid(rsp[0]), .resp_err(err[0]),
    .resp_rdata(rdat[0]), .op(opo[0]), .io_addr(ioa[0]), .common_data_bus_out(bout[0]),
    .common_data_bus_in(bus_in), .tx_done(tx_done), .rd_valid(rd_valid), .busy_cycles(bcy[0])
  );

  mem_arb_nch #(.NUM_CH(N), .LINE_SIZE(LS), .ADDR_W(AW), .RR_MODE(0), .TIMEOUT_CYC(TO)) u_fp (
    .clk(clk), .rst(rst), .req_valid(vin[1]), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy[1]), .resp_valid(rsp[1]), .resp_err(err[1]),
    .resp_rdata(rdat[1]), .op(opo[1]), .io_addr(ioa[1]), .common_data_bus_out(bout[1]),
    .common_data_bus_in(bus_in), .tx_done(tx_done), .rd_valid(rd_valid), .busy_cycles(bcy[1])
  );

  int          checks   = 0;
  int          failures = 0;
  int          ptr_m;
  logic [63:0] busy_m  [2];
  logic [LS-1:0] rdata_m [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, sel, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LS-1:0] rnd_line();
    return {$urandom, $urandom};
  endfunction

  task automatic arm(input int k);
    req_valid[k]            = 1'b1;
    req_wr[k]               = 1'($urandom_range(1));
    req_addr[k*AW +: AW]    = $urandom;
    req_wdata[k*LS +: LS]   = rnd_line();
  endtask

  // Grant rule: fixed priority picks the lowest pending index, round-robin
  // scans upward from the pointer with wrap-around.
  function automatic int winner();
    for (int i = 0; i < N; i++) begin
      int ch;
      ch = sel ? i : (ptr_m + i) % N;
      if (req_valid[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; tx_done = 1'b0; rd_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    ptr_m = 0;
    busy_m[0] = '0; busy_m[1] = '0;
    rdata_m[0] = '0; rdata_m[1] = '0;
  endtask

  // One full transaction from an IDLE cycle with requests applied.
  // c in 1..TO: correct strobe on BUSY cycle c; otherwise no completion (timeout).
  task automatic do_txn(input int c, input int wrong_pct, input bit rearm,
                        input logic [LS-1:0] dat, output int gobs);
    int w, nb;
    bit ok;
    logic wr;
    logic [AW-1:0] a;
    logic [LS-1:0] d;
    w = winner();
    if (w < 0) begin
      failures++;
      $display("FAIL no_request inst=%0d", sel);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench stimulus error");
    end
    #1;
    chk("busy_cycles_idle", bcy[sel], busy_m[sel]);
    chk("req_ready_grant", rdy[sel], N'(1) << w);
    gobs = -1;
    for (int i = 0; i < N; i++) if (rdy[sel][i]) gobs = i;
    wr = req_wr[w];
    a  = req_addr[w*AW +: AW];
    d  = req_wdata[w*LS +: LS];
    if (!sel) ptr_m = (w + 1) % N;
    ok = (c >= 1 && c <= TO);
    nb = ok ? c : TO;
    cyc();
    req_valid[w] = 1'b0;
    if (rearm) arm(w);
    for (int b = 1; b <= nb; b++) begin
      if (b == c) begin
        if (wr) tx_done = 1'b1;
        else begin rd_valid = 1'b1; bus_in = dat; end
      end else if ($urandom_range(99) < wrong_pct) begin
        if (wr) begin rd_valid = 1'b1; bus_in = rnd_line(); end
        else tx_done = 1'b1;
      end
      #1;
      chk("op_busy", opo[sel], wr ? 2'b10 : 2'b01);
      chk("io_addr_busy", ioa[sel], a);
      chk("bus_out_busy", bout[sel], d);
      chk("resp_valid_busy", rsp[sel], '0);
      chk("req_ready_busy", rdy[sel], '0);
      cyc();
      tx_done = 1'b0; rd_valid = 1'b0;
    end
    if (ok && !wr) rdata_m[sel] = dat;
    busy_m[sel] = busy_m[sel] + 64'(nb + 1);
    // Stray strobes during the response cycle must have no effect.
    tx_done  = 1'($urandom_range(1));
    rd_valid = 1'($urandom_range(1));
    bus_in   = rnd_line();
    #1;
    chk("resp_valid", rsp[sel], N'(1) << w);
    chk("resp_err", err[sel], !ok);
    chk("resp_rdata", rdat[sel], rdata_m[sel]);
    chk("op_resp", opo[sel], 2'b00);
    chk("req_ready_resp", rdy[sel], '0);
    chk("io_addr_resp", ioa[sel], a);
    cyc();
    tx_done = 1'b0; rd_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int rr_order [5];
    int fp_order [5];
    rr_order = '{0, 1, 2, 3, 0};
    fp_order = '{1, 1, 1, 1, 3};
    sel = 1'b0; rst = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    bus_in = '0; tx_done = 1'b0; rd_valid = 1'b0;
    ptr_m = 0;
    cyc(); cyc();

    // Reset values, with requests and strobes active while reset is held.
    req_valid = '1; tx_done = 1'b1; rd_valid = 1'b1; bus_in = rnd_line();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_op", opo[sel], 2'b00);
      chk("rst_io_addr", ioa[sel], '0);
      chk("rst_bus_out", bout[sel], '0);
      chk("rst_rdata", rdat[sel], '0);
      chk("rst_req_ready", rdy[sel], '0);
      chk("rst_resp_valid", rsp[sel], '0);
      chk("rst_resp_err", err[sel], 1'b0);
      chk("rst_busy_cycles", bcy[sel], '0);
    end
    sel = 1'b0;
    do_reset();

    // Idle with no requests: strobes ignored, nothing granted.
    tx_done = 1'b1; rd_valid = 1'b1; bus_in = rnd_line();
    #1;
    chk("idle_req_ready", rdy[0], '0);
    chk("idle_op", opo[0], 2'b00);
    cyc();
    tx_done = 1'b0; rd_valid = 1'b0;
    #1;
    chk("idle_resp_valid", rsp[0], '0);
    chk("idle_rdata", rdat[0], '0);
    chk("idle_busy_cycles", bcy[0], '0);

    // Single read on channel 2, data returned on the fifth BUSY cycle.
    arm(2); req_wr[2] = 1'b0; req_addr[2*AW +: AW] = 32'h100;
    do_txn(5, 0, 1'b0, {8{8'hA5}}, g);
    chk("single_read_grant", g, 2);

    // Round-robin fairness with all channels requesting continuously.
    do_reset();
    for (int k = 0; k < N; k++) arm(k);
    for (int i = 0; i < 5; i++) begin
      do_txn($urandom_range(1, 4), 0, 1'b1, rnd_line(), g);
      chk("rr_order", g, rr_order[i]);
    end

    // Wrong-kind strobe on every non-completing BUSY cycle of a read.
    req_valid = '0; arm(0); req_wr[0] = 1'b0;
    do_txn(6, 100, 1'b0, rnd_line(), g);

    // Timeouts: write with no tx_done, write completing on the last cycle,
    // read timing out under a stream of wrong-kind strobes.
    req_valid = '0; arm(1); req_wr[1] = 1'b1;
    do_txn(0, 0, 1'b0, rnd_line(), g);
    arm(1); req_wr[1] = 1'b1;
    do_txn(TO, 0, 1'b0, rnd_line(), g);
    arm(3); req_wr[3] = 1'b0;
    do_txn(0, 50, 1'b0, rnd_line(), g);

    // Reset in the middle of a read: no response, later strobe ignored.
    req_valid = '0; arm(1); req_wr[1] = 1'b0;
    g = winner();
    #1;
    chk("rstmid_grant", rdy[0], N'(1) << g);
    cyc();
    req_valid = '0;
    cyc(); cyc();
    #1;
    chk("rstmid_op_busy", opo[0], 2'b01);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rstmid_op", opo[0], 2'b00);
    chk("rstmid_resp_valid", rsp[0], '0);
    chk("rstmid_busy_cycles", bcy[0], '0);
    cyc();
    rd_valid = 1'b1; bus_in = rnd_line();
    #1;
    chk("rstmid_late_resp", rsp[0], '0);
    cyc();
    rd_valid = 1'b0;
    #1;
    chk("rstmid_late_resp2", rsp[0], '0);
    chk("rstmid_rdata", rdat[0], '0);
    chk("rstmid_busy_after", bcy[0], '0);
    chk("rstmid_op_after", opo[0], 2'b00);
    ptr_m = 0;
    busy_m[0] = '0; busy_m[1] = '0;
    rdata_m[0] = '0; rdata_m[1] = '0;

    // Fixed priority: ch1 keeps winning over ch3 while it requests.
    sel = 1'b1;
    do_reset();
    arm(1); arm(3);
    for (int i = 0; i < 5; i++) begin
      do_txn($urandom_range(1, 3), 0, (i < 3), rnd_line(), g);
      chk("fp_order", g, fp_order[i]);
    end

    // Randomized traffic on both arbitration modes.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      for (int t = 0; t < 30; t++) begin
        for (int k = 0; k < N; k++) if (!req_valid[k] && $urandom_range(1) == 1) arm(k);
        if (req_valid == '0) arm($urandom_range(N - 1));
        do_txn($urandom_range(1, 10), 25, 1'($urandom_range(1)), rnd_line(), g);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb_nch.md
MEM_ARB_NCH -- requirements
Module: mem_arb_nch

Interface
REQ-001 Parameter NUM_CH, default 4, number of requesting channels (2..8).
REQ-002 Parameter LINE_SIZE, default 512, data line width in bits.
REQ-003 Parameter ADDR_W, default 32, address width.
REQ-004 Parameter RR_MODE, default 1; 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-005 Parameter TIMEOUT_CYC, default 1024, maximum cycles waiting for memory completion.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 req_valid  input  NUM_CH  per-channel request valid.
REQ-009 req_wr  input  NUM_CH  per-channel direction: 1 write, 0 read.
REQ-010 req_addr  input  NUM_CH*ADDR_W  per-channel line address; channel k in slice k.
REQ-011 req_wdata  input  NUM_CH*LINE_SIZE  per-channel write line; channel k in slice k.
REQ-012 req_ready  output  NUM_CH  one-hot accept strobe.
REQ-013 resp_valid  output  NUM_CH  one-hot completion pulse.
REQ-014 resp_err  output  1  completion was a timeout; valid with resp_valid.
REQ-015 resp_rdata  output  LINE_SIZE  read line, shared by all channels; valid with resp_valid.
REQ-016 op  output  2  memory controller command: 00 idle, 01 read, 10 write.
REQ-017 io_addr  output  ADDR_W  memory controller address.
REQ-018 common_data_bus_out  output  LINE_SIZE  write line to memory controller.
REQ-019 common_data_bus_in  input  LINE_SIZE  read line from memory controller.
REQ-020 tx_done  input  1  write completion strobe.
REQ-021 rd_valid  input  1  read data valid strobe.
REQ-022 busy_cycles  output  64  count of cycles spent outside IDLE since reset.

Function
REQ-023 FSM states: IDLE, BUSY, RESP; one transaction outstanding at most.
REQ-024 IDLE: if any req_valid, req_ready[winner] is asserted combinationally in that cycle; winner's wr/addr/wdata and index are latched at the edge; next state BUSY.
REQ-025 req_ready is zero in BUSY and RESP and when no req_valid; requesters hold valid and payload until req_ready.
REQ-026 Round-robin: search starts at pointer p; after a grant to channel k, p becomes (k+1) mod NUM_CH; p is unchanged when no grant occurs.
REQ-027 Fixed priority: lowest-index asserted req_valid wins; pointer is unused.
REQ-028 BUSY: op = 01 (read) or 10 (write), io_addr = latched address, common_data_bus_out = latched wdata; held stable for the whole BUSY state.
REQ-029 Read completion: rd_valid in BUSY with read latched; common_data_bus_in captured; next state RESP.
REQ-030 Write completion: tx_done in BUSY with write latched; next state RESP.
REQ-031 Strobes of the wrong kind (tx_done during read, rd_valid during write) are ignored; strobes in IDLE or RESP are ignored.
REQ-032 Timeout: a counter cleared on entry to BUSY increments each BUSY cycle; if it reaches TIMEOUT_CYC-1 without completion, next state RESP with error flag set; completion in the same cycle takes precedence (no error).
REQ-033 RESP lasts exactly one cycle: resp_valid[latched index] = 1, resp_err = error flag, resp_rdata = captured line (reads), op = 00; next state IDLE.
REQ-034 Outside RESP, resp_valid = 0 and resp_err = 0; resp_rdata holds its last captured value.
REQ-035 In IDLE and RESP, op = 00; io_addr and common_data_bus_out hold last latched values.
REQ-036 Minimum request-to-request throughput: new grant possible in the cycle after RESP; req_valid-to-op latency is 1 cycle.
REQ-037 busy_cycles increments in every BUSY and RESP cycle; wraps modulo 2^64.

Reset
REQ-038 On rst: state IDLE, op = 00, io_addr = 0, common_data_bus_out = 0, resp_rdata = 0, req_ready = 0, resp_valid = 0, resp_err = 0, pointer = 0, timeout counter = 0, busy_cycles = 0.
REQ-039 rst during BUSY or RESP aborts the transaction with no resp_valid pulse; memory strobes arriving after reset are ignored.

Verification
REQ-040 Single read: ch2 read addr 0x100 at cycle 0 -> req_ready[2] cycle 0, op=01 io_addr=0x100 cycle 1; rd_valid with 0xA5.. at cycle 5 -> resp_valid[2], resp_rdata=0xA5.. at cycle 6, op=00.
REQ-041 Round-robin fairness: all 4 channels hold req_valid continuously -> grant order 0,1,2,3,0 with each memory op completed by tx_done/rd_valid.
REQ-042 Fixed priority (RR_MODE=0): ch1 and ch3 request together, repeatedly -> ch1 granted every time while it requests; ch3 only when ch1 idle.
REQ-043 Timeout: TIMEOUT_CYC=8, write issued, no tx_done -> resp_valid with resp_err=1 after 8 BUSY cycles; tx_done on the final cycle -> resp_err=0.
REQ-044 Wrong strobe: read in BUSY, tx_done pulsed -> stays BUSY, op=01; later rd_valid completes normally.
REQ-045 Reset mid-op: rst in BUSY -> next cycle op=00, no resp_valid, busy_cycles=0; a subsequent rd_valid produces no response.
